// File: rtl/piradip_sample_playback_pkg.sv
// Shared types and sizing helpers for the sample playback engine.
package piradip_sample_playback;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Room for every read in flight plus slack so one word per cycle keeps flowing.
    function automatic int fifo_depth(input int mem_latency);
        return mem_latency + 2;
    endfunction

endpackage

// File: rtl/piradip_sample_playback_fifo.sv
// Small synchronous FIFO carrying {tlast, data} from the RAM read pipe to the AXIS port.
module piradip_sample_playback_fifo #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             pop;
    logic             wr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign out_valid = (count_reg != '0);
    assign pop       = out_valid & out_ready;
    assign wr        = push & ((count_reg != CNT_W'(DEPTH)) | pop);
    assign out_data  = mem_reg[rd_ptr_reg];
    assign count     = count_reg;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mem_reg[gi] <= '0;
            end else if (wr && (wr_ptr_reg == PTR_W'(gi))) begin
                mem_reg[gi] <= push_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({wr, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/piradip_axis_sample_playback.sv
// Playback engine: walks sample RAM between start/end offsets and streams words out over AXIS.
// Optional underrun counter enabled with PIRADIP_PLAYBACK_UNDERRUN_COUNT_EN.
module piradip_axis_sample_playback
    import piradip_sample_playback::*;
#(
    parameter int DATA_WIDTH   = 128,
    parameter int OFFSET_WIDTH = 5,
    parameter int MEM_LATENCY  = 2
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    ctrl_update,
    input  logic                    ctrl_active,
    input  logic                    ctrl_one_shot,
    input  logic [OFFSET_WIDTH-1:0] start_offset,
    input  logic [OFFSET_WIDTH-1:0] end_offset,
    output logic                    stopped,
    output logic                    mem_en,
    output logic [OFFSET_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast
`ifdef PIRADIP_PLAYBACK_UNDERRUN_COUNT_EN
    ,
    output logic [31:0]             underrun_count
`endif
);

    localparam int DEPTH = fifo_depth(MEM_LATENCY);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [1:0]              rst_sync_reg;
    logic                    rst_n;
    state_t                  state_reg, state_next;
    logic                    active_prev_reg;
    logic                    pending_reg, pending_next;
    logic [OFFSET_WIDTH-1:0] addr_reg;
    logic [OFFSET_WIDTH-1:0] end_reg;
    logic [CNT_W-1:0]        in_flight_reg;
    logic [MEM_LATENCY-1:0]  en_pipe_reg;
    logic [MEM_LATENCY-1:0]  last_pipe_reg;
    logic [CNT_W-1:0]        fifo_count;
    logic                    issue;
    logic                    at_end;
    logic                    credit_ok;
    logic                    start_req;
    logic                    push;

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rst_sync_reg <= '0;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end
    assign rst_n = rst_sync_reg[1];

    assign at_end    = (addr_reg == end_reg);
    assign credit_ok = ((fifo_count + in_flight_reg) < CNT_W'(DEPTH));
    assign start_req = ctrl_active & (~active_prev_reg | ctrl_update | pending_reg);
    assign push      = en_pipe_reg[MEM_LATENCY-1];

    always_comb begin
        state_next = state_reg;
        issue      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_req) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!ctrl_active) begin
                    state_next = DRAIN;
                end else if (credit_ok) begin
                    issue = 1'b1;
                    if (at_end && ctrl_one_shot) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if ((in_flight_reg == '0) && (fifo_count == '0)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A restart request seen while draining is honoured once the engine is idle again.
    assign pending_next = (state_reg == DRAIN) & ctrl_active
                        & (pending_reg | ~active_prev_reg | ctrl_update);

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            active_prev_reg <= 1'b1;
            pending_reg     <= 1'b0;
            addr_reg        <= '0;
            end_reg         <= '0;
            in_flight_reg   <= '0;
            en_pipe_reg     <= '0;
            last_pipe_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            active_prev_reg <= ctrl_active;
            pending_reg     <= pending_next;
            if ((state_reg == IDLE) && (state_next == RUN)) begin
                addr_reg <= start_offset;
                end_reg  <= end_offset;
            end else if (issue) begin
                if (at_end) begin
                    addr_reg <= start_offset;
                    end_reg  <= end_offset;
                end else begin
                    addr_reg <= addr_reg + OFFSET_WIDTH'(1);
                end
            end
            in_flight_reg    <= in_flight_reg + CNT_W'(issue) - CNT_W'(push);
            en_pipe_reg[0]   <= issue;
            last_pipe_reg[0] <= issue & at_end;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                en_pipe_reg[i]   <= en_pipe_reg[i-1];
                last_pipe_reg[i] <= last_pipe_reg[i-1];
            end
        end
    end

    assign stopped  = (state_reg == IDLE);
    assign mem_en   = issue;
    assign mem_addr = addr_reg;

    piradip_sample_playback_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (aclk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({last_pipe_reg[MEM_LATENCY-1], mem_rdata}),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready),
        .out_data  ({m_axis_tlast, m_axis_tdata}),
        .count     (fifo_count)
    );

`ifdef PIRADIP_PLAYBACK_UNDERRUN_COUNT_EN
    localparam int AGE_W = $clog2(MEM_LATENCY + 2);

    logic [AGE_W-1:0] run_age_reg;
    logic [31:0]      underrun_reg;

    // The pipeline fill time after entering RUN is not an underrun.
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            run_age_reg  <= '0;
            underrun_reg <= '0;
        end else if ((state_reg == IDLE) && (state_next == RUN)) begin
            run_age_reg  <= '0;
            underrun_reg <= '0;
        end else if (state_reg == RUN) begin
            if (run_age_reg != AGE_W'(MEM_LATENCY + 1)) begin
                run_age_reg <= run_age_reg + AGE_W'(1);
            end else if (m_axis_tready && !m_axis_tvalid && (underrun_reg != '1)) begin
                underrun_reg <= underrun_reg + 32'd1;
            end
        end
    end

    assign underrun_count = underrun_reg;
`endif

endmodule

// File: tb/tb_piradip_axis_sample_playback.sv
// Randomised self-checking bench for piradip_axis_sample_playback against an address-sequence model.
module tb_piradip_axis_sample_playback;

    localparam int DW    = 128;
    localparam int OW    = 5;
    localparam int ML    = 3;
    localparam int DEPTH = ML + 2;
    localparam int NADDR = 1 << OW;

    logic          aclk          = 1'b0;
    logic          aresetn       = 1'b0;
    logic          ctrl_update   = 1'b0;
    logic          ctrl_active   = 1'b0;
    logic          ctrl_one_shot = 1'b0;
    logic [OW-1:0] start_offset  = '0;
    logic [OW-1:0] end_offset    = '0;
    logic          stopped;
    logic          mem_en;
    logic [OW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic          m_axis_tlast;
`ifdef PIRADIP_PLAYBACK_UNDERRUN_COUNT_EN
    logic [31:0]   underrun_count;
`endif

    piradip_axis_sample_playback #(
        .DATA_WIDTH   (DW),
        .OFFSET_WIDTH (OW),
        .MEM_LATENCY  (ML)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .ctrl_update   (ctrl_update),
        .ctrl_active   (ctrl_active),
        .ctrl_one_shot (ctrl_one_shot),
        .start_offset  (start_offset),
        .end_offset    (end_offset),
        .stopped       (stopped),
        .mem_en        (mem_en),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
`ifdef PIRADIP_PLAYBACK_UNDERRUN_COUNT_EN
        ,
        .underrun_count (underrun_count)
`endif
    );

    always #5 aclk = ~aclk;

    // Sample RAM model with fixed read latency.
    logic [DW-1:0] ram [NADDR];
    logic [DW-1:0] rd_pipe [ML];
    always @(posedge aclk) begin
        rd_pipe[0] <= mem_en ? ram[mem_addr] : '0;
        for (int i = 1; i < ML; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[ML-1];

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            cyc;
    } xfer_t;

    xfer_t         obs[$];
    int            cyc       = 0;
    int            issued    = 0;
    int            stall_err = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    logic          prev_last  = 1'b0;
    int            checks = 0;
    int            passed = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    always @(negedge aclk) begin
        xfer_t x;
        if (mem_en) issued++;
        if (prev_stall && (!m_axis_tvalid || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last))
            stall_err++;
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
        if (m_axis_tvalid && m_axis_tready) begin
            x.data = m_axis_tdata;
            x.last = m_axis_tlast;
            x.cyc  = cyc;
            obs.push_back(x);
            $display("xfer %0d cyc=%0d last=%0b data=%h", obs.size() - 1, cyc, m_axis_tlast, m_axis_tdata);
        end
    end

    // k-th word of a run from start s to end e: address and whether it closes a pass.
    function automatic void model(input int s, input int e, input int k,
                                  output logic [OW-1:0] a, output logic last);
        int len;
        len  = (((e - s) % NADDR) + NADDR) % NADDR + 1;
        a    = OW'((s + (k % len)) % NADDR);
        last = ((k % len) == (len - 1));
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic stop_and_drain(output bit ok);
        ctrl_active   = 1'b0;
        m_axis_tready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (stopped) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        ctrl_active = 1'b0;
        repeat (3) tick();
        checks++; if (stopped !== 1'b1) $display("FAIL reset_stopped: got %b want 1", stopped); else passed++;
        checks++; if (mem_en !== 1'b0) $display("FAIL reset_mem_en: got %b want 0", mem_en); else passed++;
        checks++; if (mem_addr !== '0) $display("FAIL reset_mem_addr: got %0d want 0", mem_addr); else passed++;
        checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); else passed++;
        checks++; if (m_axis_tlast !== 1'b0) $display("FAIL reset_tlast: got %b want 0", m_axis_tlast); else passed++;
        checks++; if (m_axis_tdata !== '0) $display("FAIL reset_tdata: got %h want 0", m_axis_tdata); else passed++;
        aresetn = 1'b1;
        repeat (4) tick();
        checks++; if (stopped !== 1'b1) $display("FAIL reset_release_stopped: got %b want 1", stopped); else passed++;
    endtask

    // Cyclic playback of 2..5 with tready held high.
    task automatic test_loop();
        int ob0, e_cyc;
        logic [OW-1:0] a;
        logic l;
        bit ok;
        ob0 = obs.size();
        start_offset = OW'(2); end_offset = OW'(5); ctrl_one_shot = 1'b0;
        m_axis_tready = 1'b1; ctrl_active = 1'b1;
        tick();
        e_cyc = cyc;
        checks++; if (stopped !== 1'b0) $display("FAIL loop_stopped_fall: got %b want 0", stopped); else passed++;
        for (int i = 0; i < 200 && obs.size() < ob0 + 20; i++) tick();
        checks++;
        if (obs.size() < ob0 + 20) $display("FAIL loop_count: got %0d want 20", obs.size() - ob0);
        else begin
            passed++;
            checks++;
            if (obs[ob0].cyc !== e_cyc + ML + 1)
                $display("FAIL loop_latency: got %0d want %0d", obs[ob0].cyc - e_cyc, ML + 1);
            else passed++;
            for (int k = 0; k < 20; k++) begin
                model(2, 5, k, a, l);
                checks++;
                if (obs[ob0+k].data !== ram[a] || obs[ob0+k].last !== l)
                    $display("FAIL loop_word %0d: got last=%b data=%h want addr %0d last=%b data=%h",
                             k, obs[ob0+k].last, obs[ob0+k].data, a, l, ram[a]);
                else passed++;
                if (k > 0) begin
                    checks++;
                    if (obs[ob0+k].cyc !== obs[ob0+k-1].cyc + 1)
                        $display("FAIL loop_rate %0d: gap %0d want 1", k, obs[ob0+k].cyc - obs[ob0+k-1].cyc);
                    else passed++;
                end
            end
        end
        checks++; if (stopped !== 1'b0) $display("FAIL loop_running: got stopped=%b want 0", stopped); else passed++;
        stop_and_drain(ok);
        checks++; if (!ok) $display("FAIL loop_drain: stopped=%b want 1", stopped); else passed++;
    endtask

    // One-shot pass that wraps through address 0, then an update pulse restarts it.
    task automatic test_one_shot();
        int ob0, is0, n;
        logic [OW-1:0] a;
        logic l;
        bit ok;
        ob0 = obs.size(); is0 = issued;
        start_offset = OW'(30); end_offset = OW'(1); ctrl_one_shot = 1'b1;
        m_axis_tready = 1'b1; ctrl_active = 1'b1;
        tick();
        checks++; if (stopped !== 1'b0) $display("FAIL oneshot_start: got %b want 0", stopped); else passed++;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (stopped) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) $display("FAIL oneshot_finish: stopped=%b want 1", stopped); else passed++;
        n = obs.size() - ob0;
        checks++; if (n !== 4) $display("FAIL oneshot_count: got %0d want 4", n); else passed++;
        for (int k = 0; k < n && k < 4; k++) begin
            model(30, 1, k, a, l);
            checks++;
            if (obs[ob0+k].data !== ram[a] || obs[ob0+k].last !== l)
                $display("FAIL oneshot_word %0d: got last=%b data=%h want addr %0d last=%b",
                         k, obs[ob0+k].last, obs[ob0+k].data, a, l);
            else passed++;
        end
        repeat (20) tick();
        checks++; if (issued - is0 !== 4) $display("FAIL oneshot_hold_reads: got %0d want 4", issued - is0); else passed++;
        checks++; if (stopped !== 1'b1) $display("FAIL oneshot_hold_idle: got %b want 1", stopped); else passed++;
        ctrl_update = 1'b1;
        tick();
        ctrl_update = 1'b0;
        checks++; if (stopped !== 1'b0) $display("FAIL oneshot_update_restart: got %b want 0", stopped); else passed++;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (stopped) begin ok = 1'b1; break; end
        end
        checks++; if (!ok || obs.size() - ob0 !== 8)
            $display("FAIL oneshot_second_pass: got %0d words want 8", obs.size() - ob0);
        else passed++;
        ctrl_one_shot = 1'b0;
        stop_and_drain(ok);
    endtask

    task automatic test_single_word();
        int ob0;
        logic [OW-1:0] a;
        logic l;
        bit ok;
        ob0 = obs.size();
        start_offset = OW'(7); end_offset = OW'(7); ctrl_one_shot = 1'b0;
        m_axis_tready = 1'b1; ctrl_active = 1'b1;
        for (int i = 0; i < 100 && obs.size() < ob0 + 10; i++) tick();
        checks++;
        if (obs.size() < ob0 + 10) $display("FAIL single_count: got %0d want 10", obs.size() - ob0);
        else begin
            passed++;
            for (int k = 0; k < 10; k++) begin
                model(7, 7, k, a, l);
                checks++;
                if (obs[ob0+k].data !== ram[a] || obs[ob0+k].last !== l)
                    $display("FAIL single_word %0d: got last=%b data=%h want addr %0d last=%b",
                             k, obs[ob0+k].last, obs[ob0+k].data, a, l);
                else passed++;
            end
        end
        stop_and_drain(ok);
        checks++; if (!ok) $display("FAIL single_drain: stopped=%b want 1", stopped); else passed++;
    endtask

    task automatic test_random_ready();
        int ob0, is0, s, e, out, max_out, st0, n, bad;
        logic [OW-1:0] a;
        logic l;
        bit ok;
        ob0 = obs.size(); is0 = issued; st0 = stall_err; max_out = 0; bad = 0;
        s = int'($urandom_range(0, NADDR - 1));
        e = int'($urandom_range(0, NADDR - 1));
        start_offset = OW'(s); end_offset = OW'(e); ctrl_one_shot = 1'b0;
        ctrl_active = 1'b1;
        for (int i = 0; i < 3000 && obs.size() < ob0 + 120; i++) begin
            m_axis_tready = $urandom_range(0, 1) == 1;
            tick();
            out = (issued - is0) - (obs.size() - ob0);
            if (out > max_out) max_out = out;
        end
        checks++; if (obs.size() < ob0 + 120) $display("FAIL random_count: got %0d want 120", obs.size() - ob0); else passed++;
        stop_and_drain(ok);
        checks++; if (!ok) $display("FAIL random_drain: stopped=%b want 1", stopped); else passed++;
        n = obs.size() - ob0;
        checks++; if (n !== issued - is0) $display("FAIL random_lost_dup: delivered %0d issued %0d", n, issued - is0); else passed++;
        checks++; if (max_out > DEPTH) $display("FAIL random_outstanding: got %0d want <= %0d", max_out, DEPTH); else passed++;
        checks++; if (stall_err !== st0) $display("FAIL random_stall_stable: got %0d changes want 0", stall_err - st0); else passed++;
        for (int k = 0; k < n; k++) begin
            model(s, e, k, a, l);
            if (obs[ob0+k].data !== ram[a] || obs[ob0+k].last !== l) bad++;
        end
        checks++; if (bad !== 0) $display("FAIL random_sequence s=%0d e=%0d: got %0d bad words want 0", s, e, bad); else passed++;
    endtask

    task automatic test_stop_midpass();
        int ob0, is0, is_snap, hold_err, early_err, n, lasts;
        logic [OW-1:0] a;
        logic l;
        bit ok;
        ob0 = obs.size(); is0 = issued; hold_err = 0; early_err = 0; lasts = 0;
        start_offset = OW'(0); end_offset = OW'(20); ctrl_one_shot = 1'b0;
        m_axis_tready = 1'b1; ctrl_active = 1'b1;
        for (int i = 0; i < 50 && obs.size() < ob0 + 3; i++) tick();
        m_axis_tready = 1'b0;
        repeat (3) tick();
        ctrl_active = 1'b0;
        is_snap = issued;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (stopped) hold_err++;
        end
        checks++; if (issued !== is_snap) $display("FAIL midstop_no_issue: got %0d reads want 0", issued - is_snap); else passed++;
        checks++; if (hold_err !== 0) $display("FAIL midstop_stopped_early: got %0d cycles want 0", hold_err); else passed++;
        checks++; if (m_axis_tvalid !== 1'b1) $display("FAIL midstop_pending: tvalid=%b want 1", m_axis_tvalid); else passed++;
        m_axis_tready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (stopped && (m_axis_tvalid || (issued - is0) != (obs.size() - ob0))) early_err++;
            if (stopped) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) $display("FAIL midstop_drain: stopped=%b want 1", stopped); else passed++;
        checks++; if (early_err !== 0) $display("FAIL midstop_stopped_nonempty: got %0d want 0", early_err); else passed++;
        n = obs.size() - ob0;
        checks++; if (n !== issued - is0) $display("FAIL midstop_delivered: got %0d want %0d", n, issued - is0); else passed++;
        for (int k = 0; k < n; k++) begin
            model(0, 20, k, a, l);
            if (obs[ob0+k].last) lasts++;
            checks++;
            if (obs[ob0+k].data !== ram[a] || obs[ob0+k].last !== l)
                $display("FAIL midstop_word %0d: got last=%b data=%h want addr %0d last=%b",
                         k, obs[ob0+k].last, obs[ob0+k].data, a, l);
            else passed++;
        end
        checks++; if (lasts !== 0) $display("FAIL midstop_tlast: got %0d want 0", lasts); else passed++;
        tick();
    endtask

    task automatic test_async_reset();
        int is0;
        bit ok;
        start_offset = OW'(0); end_offset = OW'(9); ctrl_one_shot = 1'b0;
        m_axis_tready = 1'b1; ctrl_active = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (m_axis_tvalid) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) $display("FAIL areset_running: tvalid=%b want 1", m_axis_tvalid); else passed++;
        #2;
        aresetn = 1'b0;
        #1;
        checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL areset_tvalid: got %b want 0", m_axis_tvalid); else passed++;
        checks++; if (mem_en !== 1'b0) $display("FAIL areset_mem_en: got %b want 0", mem_en); else passed++;
        checks++; if (stopped !== 1'b1) $display("FAIL areset_stopped: got %b want 1", stopped); else passed++;
        is0 = issued;
        repeat (3) tick();
        aresetn = 1'b1;
        repeat (10) tick();
        checks++; if (stopped !== 1'b1) $display("FAIL areset_idle: got stopped=%b want 1", stopped); else passed++;
        checks++; if (issued !== is0) $display("FAIL areset_no_restart: got %0d reads want 0", issued - is0); else passed++;
        ctrl_active = 1'b0;
        tick();
        ctrl_active = 1'b1;
        tick();
        checks++; if (stopped !== 1'b0) $display("FAIL areset_edge_restart: got stopped=%b want 0", stopped); else passed++;
        stop_and_drain(ok);
        checks++; if (!ok) $display("FAIL areset_drain: stopped=%b want 1", stopped); else passed++;
    endtask

    initial begin
        for (int i = 0; i < NADDR; i++) ram[i] = {$urandom, $urandom, $urandom, $urandom};
        test_reset();
        test_loop();
        test_one_shot();
        test_single_word();
        test_random_ready();
        test_stop_midpass();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
        $fatal(1);
    end

endmodule

// File: doc/piradip_axis_sample_playback.md
Name: piradip_axis_sample_playback

Overview:
- Stream-clock-domain playback engine sitting directly downstream of the sample buffer CSR block.
- Consumes the CSR's update/active/one_shot/start_offset/end_offset outputs and drives its stream_stopped input.
- Generates read addresses into the sample buffer RAM between start and end offsets (cyclic or one-shot).
- Absorbs fixed RAM read latency in a credit-managed output FIFO; presents samples as an AXI4-Stream manager with tlast at end of each pass.

Parameters:
- DATA_WIDTH, 128: sample word width (RAM read data and tdata).
- OFFSET_WIDTH, 5: RAM word-address width; must equal the CSR's STREAM_OFFSET_WIDTH.
- MEM_LATENCY, 2: cycles from mem_en to valid mem_rdata, range 1..4.

Ports:
- aclk  in  1  stream clock; sole clock.
- aresetn  in  1  asynchronous active-low reset.
- ctrl_update  in  1  one-cycle pulse from CSR when active/one_shot changed.
- ctrl_active  in  1  run request.
- ctrl_one_shot  in  1  1 = single pass, 0 = loop.
- start_offset  in  OFFSET_WIDTH  first word address of pass.
- end_offset  in  OFFSET_WIDTH  last word address of pass (inclusive).
- stopped  out  1  high when IDLE with nothing in flight; to CSR stream_stopped.
- mem_en  out  1  RAM read enable.
- mem_addr  out  OFFSET_WIDTH  RAM read address.
- mem_rdata  in  DATA_WIDTH  RAM data, valid MEM_LATENCY cycles after mem_en.
- m_axis_tdata  out  DATA_WIDTH  sample word.
- m_axis_tvalid  out  1  AXIS valid.
- m_axis_tready  in  1  AXIS ready.
- m_axis_tlast  out  1  marks word read from end_offset.

Behaviour:
- Reset (async assert, sync deassert internally): state IDLE, stopped=1, mem_en=0, mem_addr=0, tvalid=0, tlast=0, tdata=0, FIFO empty, credits full.
- States: IDLE, RUN, DRAIN.
- IDLE->RUN: rising edge of ctrl_active (registered prior value), or ctrl_update=1 with ctrl_active=1. Latch start/end offsets; addr=start; stopped falls same cycle as transition.
- RUN: issue one read per cycle when credits>0. FIFO depth = MEM_LATENCY+2; credit = depth - (occupancy + reads in flight). Never overflow, never drop a word.
- Address step: if addr==end_offset, next=start, else addr+1 mod 2^OFFSET_WIDTH. start>end wraps through 0. start==end gives 1-word passes.
- Offsets re-latched only at pass boundaries (after issuing end address); mid-pass offset changes are ignored.
- tlast rides in the FIFO with data; set only for the word read at latched end address.
- One-shot: after issuing end address, RUN->DRAIN.
- ctrl_active=0 in RUN: stop issuing immediately (that cycle's mem_en=0) -> DRAIN. Partial pass emits no tlast.
- DRAIN: no new reads; in-flight words delivered. When in-flight=0 and FIFO empty -> IDLE, stopped=1 next cycle.
- ctrl_active 1->0->1 while in DRAIN: rising edge recorded; engine enters RUN directly from IDLE on the cycle after drain completes.
- One-shot complete with ctrl_active still 1: remain IDLE until a new rising edge or update pulse.
- AXIS: tdata/tlast stable while tvalid & ~tready. Full throughput (1 word/cycle) with tready=1 continuously. First tvalid MEM_LATENCY+1 cycles after the RUN-entry cycle.

Optional Feature:
- Macro PIRADIP_PLAYBACK_UNDERRUN_COUNT_EN.
- With: extra output underrun_count [31:0]. Increments (saturating) each cycle in RUN with m_axis_tready=1 and m_axis_tvalid=0, excluding the first MEM_LATENCY+1 cycles after RUN entry. Cleared on reset and on IDLE->RUN.
- Without: port and logic absent.

Decomposition:
- Package piradip_sample_playback: state enum type (IDLE, RUN, DRAIN); function fifo_depth(MEM_LATENCY) = MEM_LATENCY+2.
- Sub-module piradip_sample_playback_fifo: sync FIFO {tlast, data}, parameterised depth. Provides occupancy count, push/pop, and AXIS-side valid/ready.

Test Plan:
- start=2, end=5, loop, tready=1: tdata addresses 2,3,4,5,2,3… continuous; tlast on every 4th word (addr 5); stopped=0.
- start=30, end=1 (W=5), one-shot: words 30,31,0,1; tlast on 1 only; then stopped=1 and no further mem_en.
- start=end=7, loop, tready=1: every word from addr 7 with tlast=1.
- Loop, random tready (50%), MEM_LATENCY=3: no lost/duplicated words; FIFO never exceeds 5; tdata held stable during stalls.
- Mid-pass ctrl_active=0 with tready=0 for 10 cycles: no new mem_en; pending words delivered after tready=1; stopped=1 only after FIFO empties; no tlast on partial pass.
- aresetn asserted mid-RUN with tvalid=1: tvalid/mem_en drop asynchronously; after release, stopped=1, state IDLE; restart requires a rising edge of ctrl_active.
